// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the matching step-counter width.
package div_pkg;

  localparam int DIV_N_DEFAULT = 16;
  localparam int DIV_CNT_W     = $clog2(DIV_N_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring step: shift {R,Q} left by one, then
// subtract D from the partial remainder when it fits and set the new quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic [N-1:0] rem,
  input  logic [N-1:0] quo,
  input  logic [N-1:0] dvs,
  output logic [N-1:0] rem_next,
  output logic [N-1:0] quo_next
);

  // The shifted remainder needs one extra bit; after the conditional subtract it is back below D.
  logic [N:0] shifted_s;
  logic [N:0] diff_s;

  // Shift, trial-subtract and restore.
  always_comb begin
    shifted_s = {rem, quo[N-1]};
    diff_s    = shifted_s - {1'b0, dvs};
    if (shifted_s >= {1'b0, dvs}) begin
      rem_next = diff_s[N-1:0];
      quo_next = {quo[N-2:0], 1'b1};
    end else begin
      rem_next = shifted_s[N-1:0];
      quo_next = {quo[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider, 2N/N -> N quotient + N remainder, one step per clock.
// Optional build macro DIV_EARLY_ERR_EN: error results leave BUSY after one cycle instead of N.
module div_seq
  import div_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           err
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  div_state_e    state_r, state_nx;
  logic [CW-1:0] cnt_r, cnt_nx;
  logic [N-1:0]  rem_r, rem_nx;
  logic [N-1:0]  quo_r, quo_nx;
  logic [N-1:0]  dvs_r, dvs_nx;
  logic          err_pend_r, err_pend_nx;
  logic          out_valid_r, out_valid_nx;
  logic [N-1:0]  quotient_r, quotient_nx;
  logic [N-1:0]  remainder_r, remainder_nx;
  logic          err_r, err_nx;
  logic [N-1:0]  step_rem_s;
  logic [N-1:0]  step_quo_s;
  logic          early_s;

  div_step #(.N(N)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .dvs      (dvs_r),
    .rem_next (step_rem_s),
    .quo_next (step_quo_s)
  );

`ifdef DIV_EARLY_ERR_EN
  assign early_s = err_pend_r;
`else
  assign early_s = 1'b0;
`endif

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign err       = err_r;

  // Next-state, datapath and result-register update logic.
  always_comb begin
    state_nx     = state_r;
    cnt_nx       = cnt_r;
    rem_nx       = rem_r;
    quo_nx       = quo_r;
    dvs_nx       = dvs_r;
    err_pend_nx  = err_pend_r;
    out_valid_nx = out_valid_r;
    quotient_nx  = quotient_r;
    remainder_nx = remainder_r;
    err_nx       = err_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nx    = BUSY;
          rem_nx      = dividend[2*N-1:N];
          quo_nx      = dividend[N-1:0];
          dvs_nx      = divisor;
          cnt_nx      = '0;
          err_pend_nx = (divisor == '0) | (dividend[2*N-1:N] >= divisor);
        end else begin
          state_nx = IDLE;
        end
      end
      BUSY: begin
        // On a pending error Q is frozen so it still holds the low dividend half for the remainder.
        if (!err_pend_r) begin
          rem_nx = step_rem_s;
          quo_nx = step_quo_s;
        end else begin
          rem_nx = rem_r;
          quo_nx = quo_r;
        end
        cnt_nx = cnt_r + CW'(1);
        if ((cnt_r == CNT_LAST) || early_s) begin
          state_nx     = DONE;
          out_valid_nx = 1'b1;
          err_nx       = err_pend_r;
          if (err_pend_r) begin
            quotient_nx  = '1;
            remainder_nx = quo_r;
          end else begin
            quotient_nx  = step_quo_s;
            remainder_nx = step_rem_s;
          end
        end else begin
          state_nx = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx     = IDLE;
          out_valid_nx = 1'b0;
        end else begin
          state_nx = DONE;
        end
      end
      default: begin
        state_nx     = IDLE;
        out_valid_nx = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dvs_r       <= '0;
      err_pend_r  <= 1'b0;
      out_valid_r <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nx;
      cnt_r       <= cnt_nx;
      rem_r       <= rem_nx;
      quo_r       <= quo_nx;
      dvs_r       <= dvs_nx;
      err_pend_r  <= err_pend_nx;
      out_valid_r <= out_valid_nx;
      quotient_r  <= quotient_nx;
      remainder_r <= remainder_nx;
      err_r       <= err_nx;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: reference model pushes expected results into a
// scoreboard queue; an independent monitor pops and compares on each result handshake.
module tb_div_seq;

  localparam int N    = 16;
  localparam int HALF = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           err;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         e;
    int           lat;
    time          t_acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   rdy_mode = 0;
  bit   seen = 1'b0;

  div_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  always #HALF clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2*N-1:0] dd, input logic [N-1:0] dv, input time t);
    exp_t e;
    logic [N-1:0] hi;
    hi = dd[2*N-1:N];
    e.t_acc = t;
    if (dv == 0 || hi >= dv) begin
      e.e = 1'b1;
      e.q = {N{1'b1}};
      e.r = dd[N-1:0];
    end else begin
      e.e = 1'b0;
      e.q = N'(dd / dv);
      e.r = N'(dd % dv);
    end
`ifdef DIV_EARLY_ERR_EN
    e.lat = e.e ? 1 : N;
`else
    e.lat = N;
`endif
    return e;
  endfunction

  // Consumer ready: random, forced low or forced high; changes just after the active edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: latency on first valid cycle, values on handshake.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      check("in_ready_while_valid", in_ready, 0);
      if (!seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_result: got q=%0h r=%0h with empty scoreboard", quotient, remainder);
        end else begin
          lat = int'(($time - HALF - sb[0].t_acc) / (2 * HALF));
          check("latency", lat, sb[0].lat);
        end
      end
      if (out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("err", err, e.e);
        seen = 1'b0;
      end
    end
  end

  task automatic do_op(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, w);
    end else begin
      in_valid = 1'b1;
      dividend = dd;
      divisor  = dv;
      @(posedge clk);
      sb.push_back(model(dd, dv, $time));
      #1;
      in_valid = 1'b0;
      dividend = $urandom;
      divisor  = N'($urandom);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_quotient"}, quotient, 0);
    check({tag, "_remainder"}, remainder, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    logic [N-1:0] dv;
    logic [N-1:0] hi;
    int           w;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    do_op(32'd1000, 16'd7);
    drain();
    do_op(32'hFFFE_0001, 16'hFFFF);
    drain();
    do_op(32'h0001_2345, 16'h0000);
    drain();
    do_op(32'h0005_0000, 16'h0005);
    drain();

    // Hold the result for 5 cycles with out_ready low, then release it.
    rdy_mode = 1;
    do_op(32'd1000, 16'd7);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_quotient", quotient, 16'd142);
      check("hold_remainder", remainder, 16'd6);
      @(negedge clk);
    end
    rdy_mode = 2;
    w = 0;
    while (out_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    drain();

    // Reset in the middle of a running operation.
    rdy_mode = 0;
    do_op(32'd1000, 16'd7);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'd1000, 16'd7);
    drain();

    // Random operations, biased towards non-overflowing quotients.
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 7))
        0:       dv = '0;
        1:       dv = N'($urandom_range(1, 15));
        default: dv = N'($urandom);
      endcase
      if (dv != 0 && $urandom_range(0, 3) != 0) begin
        hi = N'($urandom_range(0, int'(dv) - 1));
      end else begin
        hi = N'($urandom);
      end
      do_op({hi, N'($urandom)}, dv);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
